// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack memory handshake and
// hands each word plus its R15 value (address + 8) to the decoder through a valid/ready register.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic [31:0] r15
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] target;
    logic        unused_ok;

    assign target    = {branch_target[31:2], 2'b00};
    assign unused_ok = &{1'b0, branch_target[1:0]};

    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;

    // A redirect wins over every other event; in DRAIN the squashed request's ack
    // must still be absorbed before a new request may be issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
            instr       <= '0;
            pc_out      <= RESET_PC;
            r15         <= RESET_PC + 32'd8;
        end else begin
            case (state)
                IDLE: begin
                    if (branch_valid) begin
                        pc    <= target;
                        state <= en ? FETCH : IDLE;
                    end else if (en) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (branch_valid) begin
                        pc    <= target;
                        state <= imem_ack ? FETCH : DRAIN;
                    end else if (imem_ack) begin
                        instr       <= imem_rdata;
                        pc_out      <= pc;
                        r15         <= pc + 32'd8;
                        pc          <= pc + 32'd4;
                        instr_valid <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (branch_valid) begin
                        pc          <= target;
                        instr_valid <= 1'b0;
                        state       <= en ? FETCH : IDLE;
                    end else if (instr_ready) begin
                        instr_valid <= 1'b0;
                        state       <= en ? FETCH : IDLE;
                    end
                end
                DRAIN: begin
                    if (branch_valid) begin
                        pc <= target;
                    end
                    if (imem_ack) begin
                        state <= en ? FETCH : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a latency-configurable memory responder plus an expected-instruction
// queue that is checked whenever the decoder handshake completes.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, en, imem_req, imem_ack, branch_valid, instr_valid, instr_ready;
    logic [31:0] imem_addr, imem_rdata, branch_target, instr, pc_out, r15;

    logic        w_rst, w_en, w_req, w_ack, w_bv, w_valid, w_ready;
    logic [31:0] w_addr, w_rdata, w_bt, w_instr, w_pc, w_r15;

    int          total = 0;
    int          bad = 0;
    logic [95:0] expQ[$];

    int          ackLatency = 0;
    bit          pending;
    int          waitCnt;
    logic [31:0] pendAddr;

    fetch_unit dut (
        .clk(clk), .rst(rst), .en(en),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .pc_out(pc_out), .r15(r15)
    );

    fetch_unit #(.RESET_PC(32'hFFFFFFFC)) dut_wrap (
        .clk(clk), .rst(w_rst), .en(w_en),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
        .branch_valid(w_bv), .branch_target(w_bt),
        .instr_valid(w_valid), .instr_ready(w_ready),
        .instr(w_instr), .pc_out(w_pc), .r15(w_r15)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        case (a)
            32'h0:   return 32'hE3A01001;
            32'h4:   return 32'hE3A02002;
            32'h8:   return 32'hE0813002;
            default: return 32'hC0DE0000 ^ a;
        endcase
    endfunction

    task automatic waitNeg();
        @(negedge clk);
        #1;
    endtask

    // Memory responder: latches the address of a new request and acks it after ackLatency
    // extra cycles, even if the requester has since dropped imem_req (squashed fetch).
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 32'hBAD0BAD0;
        pending    = 1'b0;
        waitCnt    = 0;
        pendAddr   = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pending  = 1'b0;
                waitCnt  = 0;
                imem_ack = 1'b0;
            end else if (pending || imem_req) begin
                if (!pending) begin
                    pending  = 1'b1;
                    pendAddr = imem_addr;
                    waitCnt  = 0;
                end
                if (waitCnt >= ackLatency) begin
                    imem_ack   = 1'b1;
                    imem_rdata = memWord(pendAddr);
                    pending    = 1'b0;
                    waitCnt    = 0;
                end else begin
                    imem_ack   = 1'b0;
                    imem_rdata = 32'hBAD0BAD0;
                    waitCnt++;
                end
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 32'hBAD0BAD0;
            end
        end
    end

    // Every completed decoder handshake must match the oldest expected instruction.
    always @(negedge clk) begin
        #3;
        if (rst && instr_valid && instr_ready && !branch_valid) begin
            total++;
            if (expQ.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_instr got instr=%h pc=%h r15=%h want none", instr, pc_out, r15);
            end else begin
                logic [95:0] e;
                e = expQ.pop_front();
                if ({instr, pc_out, r15} !== e)
                begin
                    bad++;
                    $display("[TB] FAIL scoreboard got instr=%h pc=%h r15=%h want instr=%h pc=%h r15=%h",
                             instr, pc_out, r15, e[95:64], e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; instr_ready = 1'b0; branch_valid = 1'b0; branch_target = '0;
        ackLatency = 3;
        repeat (2) waitNeg();
        rst = 1'b1; en = 1'b1;
        repeat (2) waitNeg();
        rst = 1'b0;
        #1;
        total++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_ctrl got req=%b valid=%b instr=%h want 0 0 0", imem_req, instr_valid, instr);
        end
        total++;
        if (pc_out !== 32'h0 || r15 !== 32'h8) begin
            bad++;
            $display("[TB] FAIL reset_pc got pc_out=%h r15=%h want 0 8", pc_out, r15);
        end
        waitNeg();
        rst = 1'b1;
        waitNeg();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_release got req=%b addr=%h want 1 0", imem_req, imem_addr);
        end
        rst = 1'b0; en = 1'b0;
        waitNeg();
        rst = 1'b1;
    endtask

    task automatic test_sequential();
        int hsCycle[$];
        int cyc = 0;
        ackLatency  = 0;
        instr_ready = 1'b1;
        expQ.push_back({32'hE3A01001, 32'h0, 32'h8});
        expQ.push_back({32'hE3A02002, 32'h4, 32'hC});
        expQ.push_back({32'hE0813002, 32'h8, 32'h10});
        en = 1'b1;
        while (hsCycle.size() < 3 && cyc < 30) begin
            waitNeg();
            cyc++;
            if (instr_valid && instr_ready) begin
                hsCycle.push_back(cyc);
                if (hsCycle.size() == 3) en = 1'b0;
            end
        end
        total++;
        if (hsCycle.size() != 3) begin
            bad++;
            $display("[TB] FAIL seq_count got=%0d want=3", hsCycle.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                total++;
                if (hsCycle[i] - hsCycle[i-1] != 2) begin
                    bad++;
                    $display("[TB] FAIL seq_rate got=%0d cycles want=2", hsCycle[i] - hsCycle[i-1]);
                end
            end
        end
        waitNeg();
        total++;
        if (expQ.size() != 0 || imem_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL seq_end got pending=%0d req=%b want 0 0", expQ.size(), imem_req);
        end
    endtask

    task automatic test_latency();
        int cyc = 0;
        int reqCycles = 0;
        ackLatency  = 3;
        instr_ready = 1'b0;
        expQ.push_back({32'hC0DE000C, 32'hC, 32'h14});
        en = 1'b1;
        while (!instr_valid && cyc < 20) begin
            waitNeg();
            cyc++;
            if (imem_req) begin
                reqCycles++;
                total++;
                if (imem_addr !== 32'hC) begin
                    bad++;
                    $display("[TB] FAIL lat_addr_stable got=%h want=0000000c", imem_addr);
                end
            end
        end
        total++;
        if (reqCycles != 4) begin
            bad++;
            $display("[TB] FAIL lat_req_cycles got=%0d want=4", reqCycles);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== 32'hC0DE000C) begin
                bad++;
                $display("[TB] FAIL lat_hold got valid=%b req=%b instr=%h want 1 0 c0de000c",
                         instr_valid, imem_req, instr);
            end
            waitNeg();
        end
        instr_ready = 1'b1;
        en = 1'b0;
        waitNeg();
        total++;
        if (instr_valid !== 1'b0 || expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL lat_end got valid=%b pending=%0d want 0 0", instr_valid, expQ.size());
        end
    endtask

    task automatic test_branch_hold();
        int cyc = 0;
        ackLatency  = 0;
        instr_ready = 1'b0;
        en = 1'b1;
        while (!instr_valid && cyc < 20) begin
            waitNeg();
            cyc++;
        end
        total++;
        if (instr_valid !== 1'b1 || pc_out !== 32'h10) begin
            bad++;
            $display("[TB] FAIL bh_held got valid=%b pc_out=%h want 1 00000010", instr_valid, pc_out);
        end
        branch_valid = 1'b1; branch_target = 32'h103; instr_ready = 1'b1;
        expQ.push_back({32'hC0DE0100, 32'h100, 32'h108});
        waitNeg();
        branch_valid = 1'b0;
        total++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            bad++;
            $display("[TB] FAIL bh_redirect got valid=%b req=%b addr=%h want 0 1 00000100",
                     instr_valid, imem_req, imem_addr);
        end
        waitNeg();
        total++;
        if (instr_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL bh_new_valid got=%b want=1", instr_valid);
        end
        en = 1'b0;
        waitNeg();
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL bh_end got pending=%0d want=0", expQ.size());
        end
    endtask

    task automatic test_drain();
        for (int pass = 0; pass < 2; pass++) begin
            logic [31:0] want;
            int cyc = 0;
            want = (pass == 0) ? 32'h200 : 32'h400;
            en = 1'b0; instr_ready = 1'b1; ackLatency = 2;
            branch_valid = 1'b1; branch_target = 32'h10;
            waitNeg();
            branch_valid = 1'b0; en = 1'b1;
            waitNeg();
            total++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
                bad++;
                $display("[TB] FAIL dr_fetch got req=%b addr=%h want 1 00000010", imem_req, imem_addr);
            end
            branch_valid = 1'b1;
            branch_target = (pass == 0) ? 32'h200 : 32'h300;
            waitNeg();
            total++;
            if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL dr_enter got req=%b valid=%b want 0 0", imem_req, instr_valid);
            end
            if (pass == 1) branch_target = 32'h402;
            else branch_valid = 1'b0;
            waitNeg();
            branch_valid = 1'b0;
            total++;
            if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL dr_wait got req=%b valid=%b want 0 0", imem_req, instr_valid);
            end
            waitNeg();
            total++;
            if (imem_req !== 1'b1 || imem_addr !== want || instr_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL dr_target got req=%b addr=%h valid=%b want 1 %h 0",
                         imem_req, imem_addr, instr_valid, want);
            end
            expQ.push_back({32'hC0DE0000 ^ want, want, want + 32'd8});
            while (!instr_valid && cyc < 20) begin
                waitNeg();
                cyc++;
            end
            en = 1'b0;
            waitNeg();
            total++;
            if (expQ.size() != 0) begin
                bad++;
                $display("[TB] FAIL dr_end pass=%0d got pending=%0d want=0", pass, expQ.size());
            end
        end
    endtask

    task automatic test_branch_ack();
        ackLatency = 0; instr_ready = 1'b1;
        en = 1'b1;
        waitNeg();
        branch_valid = 1'b1; branch_target = 32'h500;
        expQ.push_back({32'hC0DE0500, 32'h500, 32'h508});
        waitNeg();
        branch_valid = 1'b0;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h500 || instr_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL ba_refetch got req=%b addr=%h valid=%b want 1 00000500 0",
                     imem_req, imem_addr, instr_valid);
        end
        waitNeg();
        en = 1'b0;
        waitNeg();
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL ba_end got pending=%0d want=0", expQ.size());
        end
    endtask

    task automatic test_wrap();
        total++;
        if (w_req !== 1'b0 || w_pc !== 32'hFFFFFFFC || w_r15 !== 32'h4) begin
            bad++;
            $display("[TB] FAIL wrap_reset got req=%b pc_out=%h r15=%h want 0 fffffffc 00000004", w_req, w_pc, w_r15);
        end
        w_rst = 1'b1; w_en = 1'b1; w_ack = 1'b1; w_rdata = 32'h12345678;
        waitNeg();
        total++;
        if (w_req !== 1'b1 || w_addr !== 32'hFFFFFFFC) begin
            bad++;
            $display("[TB] FAIL wrap_fetch got req=%b addr=%h want 1 fffffffc", w_req, w_addr);
        end
        waitNeg();
        total++;
        if (w_valid !== 1'b1 || w_instr !== 32'h12345678 || w_pc !== 32'hFFFFFFFC || w_r15 !== 32'h4) begin
            bad++;
            $display("[TB] FAIL wrap_first got valid=%b instr=%h pc=%h r15=%h want 1 12345678 fffffffc 00000004",
                     w_valid, w_instr, w_pc, w_r15);
        end
        w_ready = 1'b1; w_rdata = 32'h9ABCDEF0;
        waitNeg();
        total++;
        if (w_req !== 1'b1 || w_addr !== 32'h0) begin
            bad++;
            $display("[TB] FAIL wrap_next_addr got req=%b addr=%h want 1 00000000", w_req, w_addr);
        end
        waitNeg();
        total++;
        if (w_instr !== 32'h9ABCDEF0 || w_pc !== 32'h0 || w_r15 !== 32'h8) begin
            bad++;
            $display("[TB] FAIL wrap_second got instr=%h pc=%h r15=%h want 9abcdef0 0 8", w_instr, w_pc, w_r15);
        end
        w_en = 1'b0;
        waitNeg();
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; instr_ready = 1'b0; branch_valid = 1'b0; branch_target = '0;
        w_rst = 1'b0; w_en = 1'b0; w_ack = 1'b0; w_rdata = '0; w_bv = 1'b0; w_bt = '0; w_ready = 1'b0;
        test_reset();
        test_sequential();
        test_latency();
        test_branch_hold();
        test_drain();
        test_branch_ack();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Upstream neighbour of the RegisterFile.
- Owns the program counter and fetches 32-bit instructions from instruction memory over a req/ack handshake.
- Presents each instruction to the decoder through a single-entry valid/ready output register, together with the matching R15 value (fetch address + 8) that drives the RegisterFile R15 input.
- Accepts taken-branch redirects from writeback; any in-flight fetch is squashed on redirect.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset (word-aligned).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
en  input  1  run enable; fetching starts or continues while high
imem_req  output  1  instruction memory request
imem_addr  output  32  word-aligned fetch address; stable while imem_req is high
imem_ack  input  1  memory response; imem_rdata valid in the same cycle
imem_rdata  input  32  fetched instruction word
branch_valid  input  1  single-cycle redirect pulse
branch_target  input  32  redirect address; bits [1:0] ignored and forced to 0
instr_valid  output  1  instr, pc_out and r15 are valid
instr_ready  input  1  decoder accepts instr this cycle
instr  output  32  fetched instruction
pc_out  output  32  address of instr
r15  output  32  pc_out + 8, mod 2^32, for the RegisterFile R15 input

Behaviour:
Reset (rst low, asynchronous, any time including mid-fetch):
- pc = RESET_PC; state = IDLE.
- imem_req = 0; instr_valid = 0; instr = 0; pc_out = RESET_PC; r15 = RESET_PC + 8.
- An outstanding memory request is abandoned.

State machine (states IDLE, FETCH, HOLD, DRAIN):
- IDLE:
  - imem_req = 0.
  - If en, go to FETCH next cycle.
- FETCH:
  - imem_req = 1; imem_addr = pc.
  - On imem_ack: instr <= imem_rdata, pc_out <= pc, r15 <= pc + 8, pc <= pc + 4, instr_valid <= 1; go to HOLD.
  - Without ack: stay in FETCH.
  - en low does not abandon the request; the fetch still completes.
- HOLD:
  - imem_req = 0; instr_valid = 1; outputs held stable.
  - On instr_ready: instr_valid <= 0; go to FETCH if en, else IDLE.
- DRAIN:
  - imem_req = 0.
  - Waits for the ack of the squashed request; the data is discarded.
  - On ack, go to FETCH if en, else IDLE.

Throughput:
- Minimum 2 cycles per instruction (req+ack in cycle t, valid in t+1, ready in t+1, next req in t+2).

Redirect (branch_valid high) has priority over every other event. In all cases target = {branch_target[31:2], 2'b00}.
- IDLE or HOLD:
  - pc <= target; instr_valid <= 0. The held instruction is discarded even if instr_ready is high that cycle.
  - Go to FETCH if en, else IDLE.
- FETCH with imem_ack in the same cycle:
  - imem_rdata is discarded; pc <= target; outputs are not updated.
  - Go to FETCH, issuing the target request next cycle.
- FETCH without imem_ack:
  - pc <= target; go to DRAIN.
- DRAIN:
  - pc <= newest target; remain in DRAIN. If ack arrives in the same cycle, go to FETCH or IDLE at the new target.

Arithmetic and boundaries:
- pc + 4 and pc + 8 wrap modulo 2^32 (pc 32'hFFFFFFFC → next pc 0; r15 = 32'h00000004).
- imem_addr[1:0] is always 0.
- en toggling in HOLD only affects the transition taken after the handshake.

Test Plan:
- Reset values: assert rst low mid-run → immediately imem_req = 0, instr_valid = 0, pc_out = 0, r15 = 8. Release rst with en = 1 → FETCH, imem_addr = 0.
- Sequential fetch, zero-latency ack, memory words 0xE3A01001, 0xE3A02002, 0xE0813002, instr_ready tied high → instr/pc_out/r15 = (0xE3A01001, 0, 8), (0xE3A02002, 4, 12), (0xE0813002, 8, 16), one instruction every 2 cycles.
- Ack latency 3 cycles plus backpressure (instr_ready low for 4 cycles) → imem_addr stable during wait; instr held with instr_valid = 1; no new imem_req until the handshake.
- Branch in HOLD: branch_valid with target 0x00000103 while instr_ready = 1 → held instruction dropped, next imem_addr = 0x00000100, next r15 = 0x00000108.
- Branch during an outstanding fetch of 0x10, ack 2 cycles later → enter DRAIN, rdata discarded with no instr_valid, then imem_addr = target. Repeat with a second branch inside DRAIN → newest target is fetched.
- Wrap-around: RESET_PC = 32'hFFFFFFFC → first instr pc_out = 0xFFFFFFFC, r15 = 0x00000004; next imem_addr = 0.
